// File: rtl/mvm_sched_pkg.sv
// mvm_sched_pkg: shared types and constants for the mvm_sched job controller.
package mvm_sched_pkg;
    localparam int LANES     = 4;
    localparam int BN_W      = 4;
    localparam int ACC_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, START, WAIT_HI, WAIT_LO, ACCUM, DONE
    } state_t;

    function automatic logic signed [31:0] sext(input logic [BN_W-1:0] v);
        return 32'(signed'(v));
    endfunction
endpackage

// File: rtl/mvm_sched_acc_lane.sv
// sched_acc_lane: one signed accumulator lane; MVM_SCHED_SAT_EN selects saturating adds, else wrap.
module sched_acc_lane
    import mvm_sched_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             i_clk_sched,
    input  logic             i_rst_sched,
    input  logic             clr,
    input  logic             add_en,
    input  logic [BN_W-1:0]  din,
    output logic [ACC_W-1:0] acc
);
    logic signed [ACC_W-1:0] ext;
    logic [ACC_W-1:0] nxt;

    assign ext = ACC_W'(sext(din));
`ifdef MVM_SCHED_SAT_EN
    logic [ACC_W:0] sum;
    assign sum = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
    // top two sum bits disagree only on overflow; clamp toward the sign of the true result
    assign nxt = (sum[ACC_W] ^ sum[ACC_W-1]) ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
`else
    assign nxt = acc + ext;
`endif

    always_ff @(posedge i_clk_sched or posedge i_rst_sched) begin
        if (i_rst_sched) acc <= '0;
        else if (clr) acc <= '0;
        else if (add_en) acc <= nxt;
    end
endmodule

// File: rtl/mvm_sched.sv
// mvm_sched: job-level scheduler driving one 4-lane stochastic MVM and accumulating its results.
// Define MVM_SCHED_SAT_EN for saturating accumulators (default build wraps).
module mvm_sched
    import mvm_sched_pkg::*;
#(
    parameter int  N_W_MAX  = 32,
    parameter int  ACC_W    = ACC_W_DEF,
    parameter int  AW       = 8,
    parameter int  WAIT_MAX = 15,
    localparam int NW_W     = $clog2(N_W_MAX + 1)
) (
    input  logic                              i_clk_sched,
    input  logic                              i_rst_sched,
    input  logic                              i_job_valid,
    output logic                              o_job_ready,
    input  logic [LANES-1:0][BN_W-1:0]        i_x_job,
    input  logic [NW_W-1:0]                   i_nw_job,
    input  logic [AW-1:0]                     i_wbase_job,
    output logic                              o_w_rd,
    output logic [AW-1:0]                     o_w_addr,
    input  logic [BN_W-1:0]                   i_w_data,
    output logic                              o_start_mvm,
    output logic [LANES-1:0][BN_W-1:0]        o_x_mvm,
    output logic [BN_W-1:0]                   o_w_mvm,
    input  logic                              i_ismvm,
    input  logic [LANES-1:0][BN_W-1:0]        i_wx_result,
    output logic                              o_res_valid,
    input  logic                              i_res_ready,
    output logic [LANES-1:0][ACC_W-1:0]       o_res,
    output logic                              o_timeout
);
    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [NW_W-1:0] N_MAX     = NW_W'(N_W_MAX);
    localparam logic [CW-1:0]   WAIT_LAST = CW'(WAIT_MAX - 1);

    state_t state, nxt;
    logic [NW_W-1:0] n_r, k_r, n_in;
    logic [AW-1:0] base_r;
    logic [CW-1:0] cnt;
    logic [LANES-1:0][BN_W-1:0] cap;
    logic more, accept;

    assign n_in   = (i_nw_job > N_MAX) ? N_MAX : i_nw_job;
    assign more   = (k_r + NW_W'(1)) < n_r;
    assign accept = (state == IDLE) && i_job_valid;

    assign o_job_ready = (state == IDLE);
    assign o_w_rd      = (state == FETCH);
    assign o_start_mvm = (state == START);
    assign o_res_valid = (state == DONE);
    assign o_w_addr    = base_r + AW'(k_r);

    always_ff @(posedge i_clk_sched or posedge i_rst_sched) begin
        if (i_rst_sched) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = i_job_valid ? ((n_in == '0) ? DONE : FETCH) : IDLE;
            FETCH:   nxt = LATCH;
            LATCH:   nxt = (i_w_data == '0) ? ACCUM : START;
            START:   nxt = WAIT_HI;
            WAIT_HI: nxt = i_ismvm ? WAIT_LO : ((cnt == WAIT_LAST) ? ACCUM : WAIT_HI);
            WAIT_LO: nxt = i_ismvm ? WAIT_LO : ACCUM;
            ACCUM:   nxt = more ? FETCH : DONE;
            DONE:    nxt = i_res_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    // cap is zeroed in LATCH so skipped and timed-out passes add nothing
    always_ff @(posedge i_clk_sched or posedge i_rst_sched) begin
        if (i_rst_sched) begin
            o_x_mvm   <= '0;
            o_w_mvm   <= '0;
            o_timeout <= 1'b0;
            n_r       <= '0;
            k_r       <= '0;
            base_r    <= '0;
            cnt       <= '0;
            cap       <= '0;
        end else begin
            case (state)
                IDLE: if (i_job_valid) begin
                    o_x_mvm   <= i_x_job;
                    n_r       <= n_in;
                    base_r    <= i_wbase_job;
                    k_r       <= '0;
                    o_timeout <= 1'b0;
                end
                LATCH: begin
                    o_w_mvm <= i_w_data;
                    cap     <= '0;
                end
                START: cnt <= '0;
                WAIT_HI: begin
                    cnt <= cnt + CW'(1);
                    if (!i_ismvm && cnt == WAIT_LAST) o_timeout <= 1'b1;
                end
                WAIT_LO: if (!i_ismvm) cap <= i_wx_result;
                ACCUM: if (more) k_r <= k_r + NW_W'(1);
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sched_acc_lane #(.ACC_W(ACC_W)) u_lane (
            .i_clk_sched (i_clk_sched),
            .i_rst_sched (i_rst_sched),
            .clr         (accept),
            .add_en      (state == ACCUM),
            .din         (cap[i]),
            .acc         (o_res[i])
        );
    end
endmodule

// File: doc/mvm_sched.md
# mvm_sched

Job-level controller for the stochastic 4-lane MVM datapath. Per job it accepts one 4-element x vector (4-bit signed BN values) and a weight count. It fetches each weight from a synchronous weight memory and fires one MVM pass per weight. Each pass's four 4-bit results are summed into wide signed accumulators, and the final vector is presented on a valid/ready port. It sits between the layer sequencer (job source, result sink) and a single MVM instance.

## Interface
- N_W_MAX, 32, maximum weights per job; count port width NW_W = $clog2(N_W_MAX+1)
- ACC_W, 8, signed accumulator/result width per lane (≥5)
- AW, 8, weight-memory address width
- WAIT_MAX, 15, max cycles from start pulse to i_ismvm rising before timeout

- i_clk_sched  in  1  sole clock, all logic posedge
- i_rst_sched  in  1  asynchronous, active-high reset
- i_job_valid  in  1  job offered
- o_job_ready  out  1  high only in IDLE
- i_x_job  in  4x4  x vector, lane i = i_x_job[i]
- i_nw_job  in  NW_W  weights in job; values >N_W_MAX clamp to N_W_MAX
- i_wbase_job  in  AW  first weight address
- o_w_rd  out  1  weight read strobe
- o_w_addr  out  AW  weight address
- i_w_data  in  4  weight, valid exactly 1 cycle after o_w_rd
- o_start_mvm  out  1  one-cycle MVM start pulse
- o_x_mvm  out  4x4  latched x vector, stable for whole job
- o_w_mvm  out  4  latched current weight, stable for whole pass
- i_ismvm  in  1  MVM generating flag
- i_wx_result  in  4x4  MVM lane results, signed 4-bit
- o_res_valid  out  1  result vector valid
- i_res_ready  in  1  sink accepts
- o_res  out  4xACC_W  accumulated signed results
- o_timeout  out  1  sticky: a pass timed out this job; cleared on next job accept

## Operation
- States: IDLE, FETCH, LATCH, START, WAIT_HI, WAIT_LO, ACCUM, DONE.
- IDLE: job_ready=1. On valid&ready, latch x, count n, and base; clear accumulators, weight index k, and o_timeout. n=0 → DONE, else → FETCH.
- FETCH: o_w_rd=1, o_w_addr=base+k (wraps modulo 2^AW) → LATCH.
- LATCH: w_r←i_w_data. w_r==0 → skip the pass (zero contribution, no start pulse) and go to ACCUM with a zero-add. Otherwise → START.
- START: o_start_mvm=1 for exactly one cycle; clear the wait counter → WAIT_HI.
- WAIT_HI: i_ismvm=1 → WAIT_LO. If the counter reaches WAIT_MAX: set o_timeout, contribute zero, → ACCUM.
- WAIT_LO: wait for i_ismvm=0. In the first cycle i_ismvm is sampled 0, capture i_wx_result. The MVM clears its counters one cycle later, so a late capture is illegal. → ACCUM.
- ACCUM: acc[i] += sign-extend(captured[i]). Then k+1<n → k++, FETCH; else → DONE.
- DONE: o_res_valid=1, o_res=acc. On valid&ready → IDLE.
- o_res, o_x_mvm, and o_w_mvm hold while valid && !ready.
- Arithmetic: 4-bit two's-complement lanes sign-extended to ACC_W; behaviour on overflow per Configuration.
- Async reset at any time forces IDLE and zeroes all regs and outputs; an in-flight pass is abandoned.
- i_job_valid outside IDLE is ignored (not queued).

## Timing
- Reset values: o_job_ready=1. All other outputs are 0: o_w_rd, o_w_addr, o_start_mvm, o_x_mvm, o_w_mvm, o_res_valid, o_res, o_timeout.
- All outputs are registered or decoded from state; no combinational input→output path except o_job_ready≡(state==IDLE).
- Per nonzero weight: FETCH, LATCH, START, WAIT_HI ≥1 cycle, WAIT_LO (pass length + 1), ACCUM.
- Per zero weight: 3 cycles.
- Job accept to o_res_valid with n=0: 1 cycle.
- Back-to-back: next job can be accepted the cycle after the result handshake.

## Configuration
- MVM_SCHED_SAT_EN defined: accumulator adds saturate to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
- MVM_SCHED_SAT_EN undefined: two's-complement wrap-around, with no extra logic.

## Structure
- Package mvm_sched_pkg: state enum, lane count (4), BN width (4), ACC_W default, sign-extend function.
- Sub-module sched_acc_lane: one accumulator lane (clear, add-enable, sat/wrap per macro), instantiated 4×.

## Test plan
- n=1, w=3, mock MVM pass returns {2,−1,0,5} → o_res={2,−1,0,5}, exactly one o_start_mvm pulse, o_w_mvm=3 throughout the pass.
- n=3, weights {1,0,2}, passes return {1,1,1,1} and {−3,2,0,7} → o_res={−2,3,1,8}, two start pulses, zero weight skipped.
- MVM stub never raises i_ismvm, WAIT_MAX=15 → o_timeout=1 after 15 wait cycles, job completes with zero contribution, flag clears on next accept.
- 19 passes each returning 7 on lane 0, ACC_W=8 → 127 with MVM_SCHED_SAT_EN defined, −123 without.
- Hold i_res_ready=0 for 10 cycles in DONE → o_res stable, o_job_ready=0; ready=1 → IDLE next cycle. n=0 job → o_res=0 one cycle after accept.
- Assert i_rst_sched mid-WAIT_LO → all outputs at reset values immediately; the next job runs correctly from IDLE.
